operand_sequencer: RTL and testbench

OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

---
 rtl/operand_sequencer.sv | 111 +++++++++++
 tb/tb_operand_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/operand_sequencer.sv
// Operand sequencer: collects a minuend/subtrahend byte pair, lets an external
// subtractor settle, then captures its result and flags for a valid/ready consumer.
module operand_sequencer #(
   parameter int SETTLE = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] num1,
   output logic [7:0] num2,
   input  logic [8:0] sout,
   output logic [7:0] res_data,
   output logic       res_cout,
   output logic       res_zero,
   output logic       res_neg,
   output logic       res_ovf,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [7:0] res_count
);

   typedef enum logic [1:0] {GET_A, GET_B, WAIT, OUT} state_t;

   localparam logic [3:0] SETTLE_L = 4'(SETTLE);

   state_t     r_state;
   logic [3:0] r_settle;
   logic [7:0] r_num1;
   logic [7:0] r_num2;
   logic [7:0] r_res_data;
   logic       r_res_cout;
   logic       r_res_zero;
   logic       r_res_neg;
   logic       r_res_ovf;
   logic       r_res_valid;
   logic [7:0] r_res_count;
   logic       w_in_ready;
   logic       w_accept;

   assign w_in_ready = !reset && (r_state == GET_A || r_state == GET_B);
   assign w_accept   = in_valid && w_in_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= GET_A;
         r_settle    <= 4'd0;
         r_num1      <= 8'd0;
         r_num2      <= 8'd0;
         r_res_data  <= 8'd0;
         r_res_cout  <= 1'b0;
         r_res_zero  <= 1'b0;
         r_res_neg   <= 1'b0;
         r_res_ovf   <= 1'b0;
         r_res_valid <= 1'b0;
         r_res_count <= 8'd0;
      end else begin
         case (r_state)
            GET_A: begin
               if (w_accept) begin
                  r_num1  <= in_data;
                  r_state <= GET_B;
               end
            end
            GET_B: begin
               if (w_accept) begin
                  r_num2   <= in_data;
                  r_settle <= SETTLE_L;
                  r_state  <= WAIT;
               end
            end
            WAIT: begin
               // Operands have been stable for SETTLE edges when the count reaches 1.
               if (r_settle == 4'd1) begin
                  r_res_data  <= sout[7:0];
                  r_res_cout  <= sout[8];
                  r_res_zero  <= (sout[7:0] == 8'd0);
                  r_res_neg   <= sout[7];
                  r_res_ovf   <= (r_num1[7] != r_num2[7]) && (sout[7] != r_num1[7]);
                  r_res_valid <= 1'b1;
                  r_settle    <= 4'd0;
                  r_state     <= OUT;
               end else begin
                  r_settle <= r_settle - 4'd1;
               end
            end
            OUT: begin
               if (res_ready) begin
                  r_res_valid <= 1'b0;
                  r_res_count <= r_res_count + 8'd1;
                  r_state     <= GET_A;
               end
            end
            default: r_state <= GET_A;
         endcase
      end
   end

   assign in_ready  = w_in_ready;
   assign num1      = r_num1;
   assign num2      = r_num2;
   assign res_data  = r_res_data;
   assign res_cout  = r_res_cout;
   assign res_zero  = r_res_zero;
   assign res_neg   = r_res_neg;
   assign res_ovf   = r_res_ovf;
   assign res_valid = r_res_valid;
   assign res_count = r_res_count;

endmodule

// File: tb/tb_operand_sequencer.sv
// Bench for operand_sequencer: directed corner cases plus 256 random subtractions
// checked against an arithmetic reference model of num1 - num2.
module tb_operand_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] in_data = 8'd0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] num1;
   logic [7:0] num2;
   logic [8:0] sout;
   logic [7:0] res_data;
   logic       res_cout;
   logic       res_zero;
   logic       res_neg;
   logic       res_ovf;
   logic       res_valid;
   logic       res_ready = 1'b0;
   logic [7:0] res_count;

   int         checks = 0;
   int         failures = 0;
   logic [7:0] exp_count = 8'd0;
   logic [11:0] exp_res;

   operand_sequencer #(.SETTLE(1)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .num1(num1), .num2(num2), .sout(sout),
      .res_data(res_data), .res_cout(res_cout), .res_zero(res_zero),
      .res_neg(res_neg), .res_ovf(res_ovf), .res_valid(res_valid),
      .res_ready(res_ready), .res_count(res_count)
   );

   // External subtraction unit: two's-complement add of the inverted subtrahend.
   assign sout = {1'b0, num1} + {1'b0, ~num2} + 9'd1;

   always #5 clk = ~clk;

   // Reference: plain integer arithmetic, packed as {cout, zero, neg, ovf, data}.
   function automatic logic [11:0] ref_sub(input logic [7:0] a, input logic [7:0] b);
      int          d;
      int          sd;
      logic [7:0]  data;
      d    = int'(a) - int'(b);
      sd   = int'($signed(a)) - int'($signed(b));
      data = d[7:0];
      return {(a >= b), (data == 8'd0), data[7], (sd > 127 || sd < -128), data};
   endfunction

   function automatic logic [11:0] observed();
      return {res_cout, res_zero, res_neg, res_ovf, res_data};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Feeds one operand pair back-to-back and checks the result one edge later.
   task automatic do_op(input logic [7:0] a, input logic [7:0] b, output logic [11:0] exp);
      check("in_ready_idle", 16'(in_ready), 16'(1'b1));
      in_data  = a;
      in_valid = 1'b1;
      tick();
      check("num1_load", 16'(num1), 16'(a));
      check("in_ready_get_b", 16'(in_ready), 16'(1'b1));
      in_data = b;
      tick();
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      check("operands", {num1, num2}, {a, b});
      check("wait_ready_valid", 16'({in_ready, res_valid}), 16'(2'b00));
      tick();
      exp = ref_sub(a, b);
      check("res_valid_rise", 16'(res_valid), 16'(1'b1));
      check("result", 16'(observed()), 16'(exp));
   endtask

   // Holds the result with res_ready low while offering junk input bytes.
   task automatic hold(input int cycles, input logic [7:0] a, input logic [7:0] b,
                       input logic [11:0] exp);
      for (int i = 0; i < cycles; i++) begin
         in_valid = 1'b1;
         in_data  = 8'($urandom);
         tick();
         check("hold_result", 16'(observed()), 16'(exp));
         check("hold_valid_ready", 16'({res_valid, in_ready}), 16'(2'b10));
         check("hold_operands", {num1, num2}, {a, b});
      end
      in_valid = 1'b0;
   endtask

   task automatic take(input logic [11:0] exp);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      exp_count = exp_count + 8'd1;
      check("res_valid_clear", 16'(res_valid), 16'(1'b0));
      check("res_count", 16'(res_count), 16'(exp_count));
      check("result_kept", 16'(observed()), 16'(exp));
      check("in_ready_after_take", 16'(in_ready), 16'(1'b1));
   endtask

   initial begin
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] pairs [8];

      // Reset state, including in_ready low while reset is high.
      tick();
      tick();
      check("reset_outputs", 16'({in_ready, res_valid, res_count, observed(), num1, num2}),
            16'(0));
      check("reset_in_ready", 16'(in_ready), 16'(1'b0));
      reset = 1'b0;
      #1;
      check("in_ready_after_reset", 16'(in_ready), 16'(1'b1));

      // res_ready without a pending result does nothing.
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check("idle_ready_no_effect", 16'({res_valid, res_count, in_ready}), 16'({1'b0, 8'd0, 1'b1}));

      // Directed corner cases.
      pairs = '{8'h80, 8'h01, 8'h40, 8'h80, 8'h80, 8'h80, 8'h40, 8'h20};
      for (int p = 0; p < 4; p++) begin
         a = pairs[2*p];
         b = pairs[2*p+1];
         do_op(a, b, exp_res);
         if (p == 3) hold(10, a, b, exp_res);
         take(exp_res);
         $display("directed op a=%h b=%h res=%h count=%0d", a, b, res_data, res_count);
      end
      check("spec_80_01", 16'(ref_sub(8'h80, 8'h01)), 16'({4'b1001, 8'h7F}));
      check("spec_40_80", 16'(ref_sub(8'h40, 8'h80)), 16'({4'b0011, 8'hC0}));

      // Reset during WAIT discards the partial operation.
      in_data  = 8'h10;
      in_valid = 1'b1;
      tick();
      in_data = 8'h05;
      tick();
      in_valid = 1'b0;
      reset    = 1'b1;
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check("reset_in_wait", 16'({in_ready, res_valid, res_count, observed(), num1, num2}),
            16'(0));
      check("reset_wait_operands", {num1, num2}, 16'h0000);
      reset = 1'b0;
      exp_count = 8'd0;
      #1;
      do_op(8'h05, 8'h10, exp_res);
      check("after_reset_result", 16'(observed()), 16'({4'b0010, 8'hF5}));
      take(exp_res);
      check("after_reset_count", 16'(res_count), 16'(8'd1));
      $display("post-reset op a=05 b=10 res=%h count=%0d", res_data, res_count);

      // 256 random operations: counter wraps through 255 -> 0.
      for (int i = 0; i < 256; i++) begin
         a = 8'($urandom);
         b = 8'($urandom);
         do_op(a, b, exp_res);
         hold(int'($urandom_range(0, 2)), a, b, exp_res);
         take(exp_res);
         $display("random op %0d a=%h b=%h res=%h count=%0d", i, a, b, res_data, res_count);
      end
      check("final_count_wrapped", 16'(res_count), 16'(8'd1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
